mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage load/store unit of the Chronos pipeline, sitting directly downstream of the EX/MEM register. It takes the memory operation the EX stage produced (ALU address, store data, funct3 access type, destination register) and runs a registered valid/ready handshake to data memory. It holds the pipeline with `stall` until the access completes, then returns aligned, sign- or zero-extended load data to the WB stage.

## Interface
No parameters.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: EX/MEM holds a memory operation this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_type` in 3: funct3.
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- `req_addr` in 32: effective byte address (alu_out).
- `req_wdata` in 32: rs2 store data.
- `req_rd` in 5: load destination register.
- `stall` out 1: hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `req_fault` out 1: one-cycle pulse for a misaligned access or an illegal `req_type`.
- `wb_valid` out 1, `wb_rd` out 5, `wb_data` out 32: load writeback.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32, `dmem_be` out 4: data-memory request.
- `dmem_ready` in 1: memory accepts the request this cycle.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response.

## Operation
- FSM states: IDLE, REQ, WAIT.
- Fault check in IDLE when `req_valid`=1. A fault is any of:
  - illegal type: load type 011/110/111, or store type ≥011;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0.
- On a fault:
  - no memory traffic, state stays IDLE;
  - `req_fault`=1 on the next cycle; `stall`=0.
- IDLE with `req_valid`=1 and no fault:
  - latch write, type, addr[1:0], rd;
  - register `dmem_addr`={addr[31:2],2'b00}, plus `dmem_we`, `dmem_be`, `dmem_wdata`;
  - go to REQ.
- REQ:
  - `dmem_req`=1; all `dmem_*` outputs held stable until `dmem_ready`=1.
  - On ready: a store goes to IDLE; a load goes to WAIT.
  - `dmem_req` drops on the edge after ready.
- WAIT: on `dmem_rvalid`=1, register the extracted load data and go to IDLE.
- `dmem_rvalid` is ignored in IDLE and REQ. Memory never returns rvalid in the same cycle as ready.
- Store formatting:
  - SB: `dmem_be`=1<<addr[1:0]; `dmem_wdata`={4{wdata[7:0]}}.
  - SH: `dmem_be`=addr[1]?1100:0011; `dmem_wdata`={2{wdata[15:0]}}.
  - SW: `dmem_be`=1111; `dmem_wdata`=wdata.
- Load extraction:
  - Byte lane: rdata>>(8·addr[1:0]); halfword lane: addr[1]?rdata[31:16]:rdata[15:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes rdata through.
  - Loads have `dmem_be`=1111 and `dmem_we`=0.
- Writeback:
  - `wb_valid` pulses for exactly one cycle after the rvalid cycle.
  - A load with rd=0 still accesses memory but leaves `wb_valid`=0.
  - `wb_rd` and `wb_data` hold their last value when `wb_valid`=0.
- `stall` is combinational:
  - (IDLE & `req_valid` & no fault), or
  - (REQ & ~(store & `dmem_ready`)), or
  - (WAIT & ~`dmem_rvalid`).
- `stall` drops in the completion cycle so EX/MEM advances on that edge. The same instruction is never issued twice.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE;
  - `dmem_req`, `dmem_we`, `wb_valid`, `req_fault`=0;
  - `dmem_addr`, `dmem_wdata`, `wb_data`=0; `dmem_be`=0000; `wb_rd`=0.
- After reset, a late `dmem_rvalid` from the aborted access is ignored.
- `stall` is 0 while `rst`=1.
- Store with zero-wait memory:
  - cycle 0 IDLE, stall=1;
  - cycle 1 REQ, ready=1, stall=0.
- Load with zero-wait memory:
  - cycle 0 IDLE, stall=1;
  - cycle 1 REQ, ready=1, stall=1;
  - cycle 2 WAIT, rvalid=1, stall=0;
  - cycle 3 `wb_valid`=1.
- Each ready-wait cycle adds one cycle of stall in REQ; each rvalid-wait cycle adds one in WAIT.
- Back-to-back operations: a new `req_valid` seen in IDLE on the cycle after completion issues immediately. No dead cycles beyond those listed above.
- `req_valid` falling while `stall`=1 is not permitted. Upstream holds its outputs under stall.

## Test plan
- SW to 0x100, wdata 0xDEADBEEF, ready held 0 for 2 cycles:
  - `dmem_addr`=0x100, be=1111, `dmem_req` stable for 3 cycles;
  - stall high for 3 cycles, low in the ready cycle.
- LB from 0x203, rdata 0x80AABBCC: `wb_data`=0xFFFFFF80, `wb_rd`=req_rd, `wb_valid` for one cycle at cycle 3.
- LBU from the same address and data: `wb_data`=0x00000080.
- LHU from 0x202 with rdata 0x1234ABCD: `wb_data`=0x00001234.
- SH to 0x002, wdata 0x0000BEEF: be=1100, `dmem_wdata`=0xBEEFBEEF.
- LW from 0x101: no `dmem_req`, `req_fault` pulse, stall=0, `wb_valid`=0.
- LW to 0x1B (misaligned) and LB with rd=0:
  - LW 0x1B faults with no memory traffic;
  - LB with rd=0 completes the access, `wb_valid` stays 0.
- Reset asserted in WAIT with rvalid arriving 1 cycle later:
  - all outputs return to reset values immediately;
  - no `wb_valid`; the next LW issues normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns an EX/MEM memory op into a registered valid/ready
// data-memory transaction, stalls the pipeline until it completes and returns load data.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        req_fault,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_next;
  logic        lat_write;
  logic [2:0]  lat_type;
  logic [1:0]  lat_off;
  logic [4:0]  lat_rd;
  logic        illegal, fault, accept, load_done;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt, shifted, load_data;
  logic [15:0] rhalf;

  always_comb begin
    illegal = req_write ? (req_type > 3'd2)
                        : (req_type == 3'b011 || req_type[2:1] == 2'b11);
    fault   = illegal
            | ((req_type[1:0] == 2'b01) & req_addr[0])
            | ((req_type[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  // Loads always read the full word; the wanted lane is extracted on the response.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = 32'h0;
    if (req_write) begin
      case (req_type[1:0])
        2'b00: begin
          be_fmt    = 4'b0001 << req_addr[1:0];
          wdata_fmt = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_fmt    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_fmt = {2{req_wdata[15:0]}};
        end
        default: begin
          be_fmt    = 4'b1111;
          wdata_fmt = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    accept     = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !fault) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall = !(lat_write && dmem_ready);
        if (dmem_ready) state_next = lat_write ? IDLE : WAIT;
      end
      WAIT: begin
        stall = !dmem_rvalid;
        if (dmem_rvalid) begin
          load_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_comb begin
    shifted = dmem_rdata >> {lat_off, 3'b000};
    rhalf   = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_type)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, rhalf};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // wb_rd/wb_data only move on a real writeback so they hold while wb_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write  <= 1'b0;
      lat_type   <= 3'b000;
      lat_off    <= 2'b00;
      lat_rd     <= 5'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_be    <= 4'b0000;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'h0;
      req_fault  <= 1'b0;
    end else begin
      req_fault <= (state == IDLE) && req_valid && fault;
      wb_valid  <= 1'b0;
      if (accept) begin
        lat_write  <= req_write;
        lat_type   <= req_type;
        lat_off    <= req_addr[1:0];
        lat_rd     <= req_rd;
        dmem_req   <= 1'b1;
        dmem_we    <= req_write;
        dmem_addr  <= {req_addr[31:2], 2'b00};
        dmem_wdata <= wdata_fmt;
        dmem_be    <= be_fmt;
      end
      if (state == REQ && dmem_ready) dmem_req <= 1'b0;
      if (load_done && lat_rd != 5'd0) begin
        wb_valid <= 1'b1;
        wb_rd    <= lat_rd;
        wb_data  <= load_data;
      end
    end
  end

endmodule
